reg_file_mp: RTL

- Parametrised multi-port register file and successor to the 2R/1W CPU register file.
- Configurable data width, depth and read-port count; two write ports (WB-stage and late-load path).
- Optional same-cycle write-to-read bypass, optional hard-wired zero register.
- After reset, a sequenced clear walks every entry to zero and asserts busy so the pipeline stalls until the file is clean.

---
 rtl/reg_file_mp_pkg.sv | 17 +
 rtl/reg_file_mp_if.sv | 37 +++
 rtl/reg_file_mp_read_mux.sv | 46 ++++
 rtl/reg_file_mp.sv | 105 ++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_mp_pkg
// Shared definitions for the multi-port register file: default geometry,
// the clear/run state encoding and the hard-wired zero register address.
// ---------------------------------------------------------------------------
package reg_file_mp_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_AW   = 5;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if
// Bundles the read and write ports of the register file.
//   RN      : NUM_RD packed read addresses, port i at [i*AW +: AW]
//   RD      : NUM_RD packed read data,     port i at [i*DW +: DW]
//   WEA/WNA/WDA : write port A (wins on address collision)
//   WEB/WNB/WDB : write port B
//   busy    : clear sequence running, writes ignored, reads return 0
//   collide : sticky flag, both ports wrote the same address in one cycle
// master = pipeline side, slave = register file.
// ---------------------------------------------------------------------------
interface reg_file_mp_if #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*AW-1:0] RN;
    logic [NUM_RD*DW-1:0] RD;
    logic                 WEA;
    logic [AW-1:0]        WNA;
    logic [DW-1:0]        WDA;
    logic                 WEB;
    logic [AW-1:0]        WNB;
    logic [DW-1:0]        WDB;
    logic                 busy;
    logic                 collide;

    modport master (
        output RN, WEA, WNA, WDA, WEB, WNB, WDB,
        input  RD, busy, collide
    );

    modport slave (
        input  RN, WEA, WNA, WDA, WEB, WNB, WDB,
        output RD, busy, collide
    );
endinterface

// File: rtl/reg_file_mp_read_mux.sv
// ---------------------------------------------------------------------------
// rf_read_mux
// Data selection for one read port.
//   busy      : clear in progress, force 0
//   rn        : read address
//   arr_data  : stored entry at rn
//   wea/wna/wda, web/wnb/wdb : this cycle's write ports, used for bypass
//   rd        : read data
// Priority: busy, zero register, port A bypass, port B bypass, array.
// ---------------------------------------------------------------------------
module rf_read_mux
    import reg_file_mp_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          busy,
    input  logic [AW-1:0] rn,
    input  logic [DW-1:0] arr_data,
    input  logic          wea,
    input  logic [AW-1:0] wna,
    input  logic [DW-1:0] wda,
    input  logic          web,
    input  logic [AW-1:0] wnb,
    input  logic [DW-1:0] wdb,
    output logic [DW-1:0] rd
);

    // Port A is checked before port B so a forwarded value always matches
    // what the array will hold after a same-address collision.
    always_comb begin
        rd = arr_data;
        if (busy) begin
            rd = '0;
        end else if ((ZERO_REG != 0) && (rn == AW'(REG_ZERO))) begin
            rd = '0;
        end else if ((BYPASS != 0) && wea && (wna == rn)) begin
            rd = wda;
        end else if ((BYPASS != 0) && web && (wnb == rn)) begin
            rd = wdb;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Parametrised register file with NUM_RD combinational read ports and two
// write ports. After reset a clear sequence walks every entry to zero while
// busy is high; the pipeline must stall until busy drops.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : reg_file_mp_if slave (read/write ports, busy, collide)
// ---------------------------------------------------------------------------
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]       mem [DEPTH];
    rf_state_e           state;
    logic [AW:0]         clr_idx;
    logic                collide_q;
    logic                wa_ok;
    logic                wb_ok;
    logic                collision;
    logic [NUM_RD*DW-1:0] rd_all;

    // Writes to the zero register are discarded before arbitration, so a
    // double write to address 0 is not counted as a collision.
    always_comb begin
        wa_ok     = (state == RUN) && bus.WEA &&
                    !((ZERO_REG != 0) && (bus.WNA == AW'(REG_ZERO)));
        collision = wa_ok && bus.WEB && (bus.WNA == bus.WNB);
        wb_ok     = (state == RUN) && bus.WEB && !collision &&
                    !((ZERO_REG != 0) && (bus.WNB == AW'(REG_ZERO)));
    end

    // Clear FSM and write ports. Reset only touches control state; the
    // array is wiped afterwards by the CLEAR walk, one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_idx   <= '0;
            collide_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    mem[clr_idx[AW-1:0]] <= '0;
                    clr_idx              <= clr_idx + 1'b1;
                    if (clr_idx == (AW+1)'(DEPTH - 1)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (wa_ok) begin
                        mem[bus.WNA] <= bus.WDA;
                    end
                    if (wb_ok) begin
                        mem[bus.WNB] <= bus.WDB;
                    end
                    if (collision) begin
                        collide_q <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    assign bus.busy    = (state == CLEAR);
    assign bus.collide = collide_q;

    // One selection slice per read port.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_mux #(
            .DW       (DW),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .busy     (bus.busy),
            .rn       (bus.RN[i*AW +: AW]),
            .arr_data (mem[bus.RN[i*AW +: AW]]),
            .wea      (bus.WEA),
            .wna      (bus.WNA),
            .wda      (bus.WDA),
            .web      (bus.WEB),
            .wnb      (bus.WNB),
            .wdb      (bus.WDB),
            .rd       (rd_all[i*DW +: DW])
        );
    end

    assign bus.RD = rd_all;

endmodule
